// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Owns the program counter for a LEGv8 core. It fetches one 32-bit
// instruction at a time from instruction memory over a req/ack handshake and
// presents it to the decode stage with a valid/ready handshake. When decode
// accepts a CBZ whose branch is taken, the next fetch address becomes
// pc + sign_extend(imm19) * 4, where imm19 is instruction[23:5]. Otherwise
// the next fetch address is pc + 4.
//
// Operation is a three-state loop:
//   RESET -> REQ    one cycle after reset is released
//   REQ   -> HOLD   on imem_ack
//   HOLD  -> REQ    on instr_ready
// Sustained throughput is therefore one instruction every two cycles. Each
// memory wait state adds one cycle.
//
// Every output comes straight from a flop, so no input reaches an output
// through combinational logic.
//
// Parameters
//   ADDR_W    PC / instruction-memory address width. Must be at least 21,
//             because the branch offset is 21 bits wide.
//   RESET_PC  PC value after reset. Must be 4-byte aligned.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   imem_req      fetch request; held high until acked
//   imem_addr     fetch address; stable while imem_req=1
//   imem_ack      imem_rdata is valid this cycle; ignored unless requesting
//   imem_rdata    fetched instruction word
//   instruction   instruction presented to the decoder
//   instr_valid   instruction/pc are valid
//   instr_ready   decode accepts the presented instruction
//   branch_taken  Branch AND Zero for the presented word; used only on accept
//   pc            address of the presented instruction
//   fetch_count   number of instructions accepted since reset; wraps at 2^32
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned         ADDR_W   = 64,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_taken,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              imem_req_q, imem_req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       fetch_count_q, fetch_count_d;

  // CB-type offset: imm19 sign-extended to ADDR_W and scaled by 4.
  // The two zero LSBs keep every target 4-byte aligned.
  logic [ADDR_W-1:0] branch_off;
  assign branch_off = {{(ADDR_W-21){instr_q[23]}}, instr_q[23:5], 2'b00};

  // Both targets are computed from the held pc. The adds wrap silently
  // modulo 2^ADDR_W.
  logic [ADDR_W-1:0] seq_target;
  logic [ADDR_W-1:0] br_target;
  assign seq_target = pc_q + ADDR_W'(4);
  assign br_target  = pc_q + branch_off;

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      S_RESET: begin
        state_d     = S_REQ;
        imem_req_d  = 1'b1;
        imem_addr_d = RESET_PC;
      end

      S_REQ: begin
        // Without an ack, the request and its address simply stay put.
        if (imem_ack) begin
          instr_d       = imem_rdata;
          pc_d          = imem_addr_q;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
          state_d       = S_HOLD;
        end
      end

      S_HOLD: begin
        // imem_ack is ignored here because no request is outstanding.
        // branch_taken matters only on the accepting edge.
        if (instr_ready) begin
          fetch_count_d = fetch_count_q + 32'd1;
          instr_valid_d = 1'b0;
          imem_req_d    = 1'b1;
          imem_addr_d   = branch_taken ? br_target : seq_target;
          state_d       = S_REQ;
        end
      end

      default: begin
        state_d    = S_RESET;
        imem_req_d = 1'b0;
      end
    endcase
  end

  // NOTE: all state is held in plain flops with no memory arrays, so each
  // flop is cleared by the async reset. That reset is what drops imem_req
  // immediately when a request is abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge values of every other flop.
      state_q       <= S_RESET;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= RESET_PC;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
      pc_q          <= RESET_PC;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instruction = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign fetch_count = fetch_count_q;

endmodule
